// File: rtl/ysyx_22041412_pkg.sv
// Shared decode definitions for the ysyx_22041412 core: opcode constants,
// the ebreak encoding, opcode classes and the decoded-bundle struct.
package ysyx_22041412_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Widest supported datapath; narrower cores use the low XLEN bits of imm.
  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    CLS_I, CLS_U, CLS_J, CLS_B, CLS_S, CLS_R, CLS_SYS, CLS_ILL
  } op_class_t;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic                func7;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [MAX_XLEN-1:0] imm;
    logic                src_a_pc;
    logic                src_a_zero;
    logic                src_b_imm;
    logic                mul_en;
    logic                ebreak;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/ysyx_22041412_dec_core.sv
// Combinational RV32/RV64 decoder: raw instruction -> decoded bundle.
module ysyx_22041412_dec_core
  import ysyx_22041412_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]  instr,
  output dec_bundle_t  bundle
);

  op_class_t           cls;
  logic [MAX_XLEN-1:0] imm_i, imm_u, imm_j, imm_b, imm_s;

  // Immediates are sign-extended to the widest datapath; the top slices XLEN.
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};

  // Classify the opcode; W-form opcodes exist only on RV64.
  always_comb begin
    cls = CLS_ILL;
    case (instr[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: cls = CLS_I;
      OPC_OP_IMM_32:                  cls = (XLEN == 64) ? CLS_I : CLS_ILL;
      OPC_LUI, OPC_AUIPC:             cls = CLS_U;
      OPC_JAL:                        cls = CLS_J;
      OPC_BRANCH:                     cls = CLS_B;
      OPC_STORE:                      cls = CLS_S;
      OPC_OP:                         cls = CLS_R;
      OPC_OP_32:                      cls = (XLEN == 64) ? CLS_R : CLS_ILL;
      OPC_SYSTEM:                     cls = CLS_SYS;
      default:                        cls = CLS_ILL;
    endcase
  end

  // Build the bundle; raw fields always pass through, flags only when legal.
  always_comb begin
    bundle            = '0;
    bundle.opcode     = instr[6:0];
    bundle.func3      = instr[14:12];
    bundle.func7      = instr[30];
    bundle.rs1        = instr[19:15];
    bundle.rs2        = instr[24:20];
    bundle.rd         = instr[11:7];
    bundle.illegal    = (cls == CLS_ILL);
    case (cls)
      CLS_I:   bundle.imm = imm_i;
      CLS_U:   bundle.imm = imm_u;
      CLS_J:   bundle.imm = imm_j;
      CLS_B:   bundle.imm = imm_b;
      CLS_S:   bundle.imm = imm_s;
      default: bundle.imm = '0;
    endcase
    bundle.src_a_pc   = (instr[6:0] == OPC_AUIPC) || (instr[6:0] == OPC_JAL) ||
                        (instr[6:0] == OPC_JALR);
    bundle.src_a_zero = (instr[6:0] == OPC_LUI);
    bundle.src_b_imm  = (cls == CLS_I) || (cls == CLS_U) || (cls == CLS_S) || (cls == CLS_J);
    bundle.mul_en     = (cls == CLS_R) && instr[25];
    bundle.ebreak     = (instr == INSTR_EBREAK);
    if (cls == CLS_ILL) begin
      bundle.src_a_pc   = 1'b0;
      bundle.src_a_zero = 1'b0;
      bundle.src_b_imm  = 1'b0;
      bundle.mul_en     = 1'b0;
      bundle.ebreak     = 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22041412_idu_queue.sv
// Instruction-decode stage: DEPTH-entry fetch queue, head decode and a
// registered decode bundle presented to EXU over valid/ready.
module ysyx_22041412_idu_queue
  import ysyx_22041412_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_func3,
  output logic                     out_func7,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_src_a_pc,
  output logic                     out_src_a_zero,
  output logic                     out_src_b_imm,
  output logic                     out_mul_en,
  output logic                     out_ebreak,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  dec_bundle_t     head;

  // Ready depends only on registered occupancy, so a same-cycle pop cannot free a slot.
  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign pop       = (count != '0) && (!out_valid || out_ready);
  assign out_count = count;

  ysyx_22041412_dec_core #(.XLEN(XLEN)) u_dec_core (
    .instr  (instr_q[rd_ptr]),
    .bundle (head)
  );

  // Queue storage; entries beyond count are don't-care, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= in_instr;
      pc_q[wr_ptr]    <= in_pc;
    end
  end

  // Pointers and occupancy; flush behaves like reset for queue state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register: load head when free or being consumed, else drop valid on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_opcode     <= '0;
      out_func3      <= '0;
      out_func7      <= 1'b0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_src_a_pc   <= 1'b0;
      out_src_a_zero <= 1'b0;
      out_src_b_imm  <= 1'b0;
      out_mul_en     <= 1'b0;
      out_ebreak     <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid      <= 1'b1;
      out_pc         <= pc_q[rd_ptr];
      out_opcode     <= head.opcode;
      out_func3      <= head.func3;
      out_func7      <= head.func7;
      out_rs1        <= head.rs1;
      out_rs2        <= head.rs2;
      out_rd         <= head.rd;
      out_imm        <= head.imm[XLEN-1:0];
      out_src_a_pc   <= head.src_a_pc;
      out_src_a_zero <= head.src_a_zero;
      out_src_b_imm  <= head.src_b_imm;
      out_mul_en     <= head.mul_en;
      out_ebreak     <= head.ebreak;
      out_illegal    <= head.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
